// File: rtl/traffic_light_fsm.sv
// Two-road intersection phase controller; sole master of the shared interval timer.
// Optional pedestrian phase enabled by defining TLC_WALK_EN.
module traffic_light_fsm #(
   parameter logic [3:0] T_BASE = 4'd6,
   parameter logic [3:0] T_EXT  = 4'd3,
   parameter logic [3:0] T_YEL  = 4'd2,
   parameter logic [3:0] T_RED  = 4'd1,
   parameter logic [3:0] T_WALK = 4'd4
) (
   input  logic       clk1,
   input  logic       rst_n,
   input  logic       sensor,
   input  logic       walk_request,
   input  logic       expired,
   output logic       start_timer,
   output logic [3:0] value,
   output logic [1:0] main_light,
   output logic [1:0] side_light,
   output logic       walk_light,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      MG   = 3'd0,
      MY   = 3'd1,
      AR1  = 3'd2,
      SG   = 3'd3,
      SGX  = 3'd4,
      SY   = 3'd5,
      AR2  = 3'd6,
      WALK = 3'd7
   } state_t;

   localparam logic [1:0] L_RED = 2'b00;
   localparam logic [1:0] L_YEL = 2'b01;
   localparam logic [1:0] L_GRN = 2'b10;

   state_t     cur, nxt;
   logic       arm, car_waiting, walk_pending;
   logic [1:0] blank;
   logic       qual, enter;
   logic [3:0] ivl;
   logic [1:0] main_n, side_n;

   assign state = cur;
   // Expired only counts once the timer has had time to restart after our pulse.
   assign qual  = expired && (blank == 2'd0);

   always_comb begin
      nxt   = cur;
      enter = 1'b0;
      if (arm) begin
         nxt   = MG;
         enter = 1'b1;
      end else begin
         case (cur)
            MG:  if (qual) begin enter = 1'b1; nxt = (car_waiting || sensor) ? MY : MG; end
            MY:  if (qual) begin enter = 1'b1; nxt = AR1; end
            AR1: if (qual) begin enter = 1'b1; nxt = walk_pending ? WALK : SG; end
            SG:  if (qual) begin enter = 1'b1; nxt = sensor ? SGX : SY; end
            SGX: if (qual) begin enter = 1'b1; nxt = SY; end
            SY:  if (qual) begin enter = 1'b1; nxt = AR2; end
            AR2: if (qual) begin enter = 1'b1; nxt = MG; end
`ifdef TLC_WALK_EN
            WALK: if (qual) begin enter = 1'b1; nxt = SG; end
`endif
            default: begin enter = 1'b1; nxt = MG; end
         endcase
      end
   end

   always_comb begin
      ivl    = T_BASE;
      main_n = L_RED;
      side_n = L_RED;
      case (nxt)
         MG:      begin ivl = T_BASE; main_n = L_GRN; end
         MY:      begin ivl = T_YEL;  main_n = L_YEL; end
         AR1:     ivl = T_RED;
         SG:      begin ivl = T_BASE; side_n = L_GRN; end
         SGX:     begin ivl = T_EXT;  side_n = L_GRN; end
         SY:      begin ivl = T_YEL;  side_n = L_YEL; end
         AR2:     ivl = T_RED;
         WALK:    ivl = T_WALK;
         default: ivl = T_BASE;
      endcase
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         cur         <= MG;
         arm         <= 1'b1;
         blank       <= 2'd0;
         start_timer <= 1'b0;
         value       <= 4'd0;
         main_light  <= L_GRN;
         side_light  <= L_RED;
         car_waiting <= 1'b0;
      end else begin
         cur         <= nxt;
         arm         <= 1'b0;
         start_timer <= enter;
         main_light  <= main_n;
         side_light  <= side_n;
         if (enter) value <= ivl;
         if (enter)                blank <= 2'd2;
         else if (blank != 2'd0)   blank <= blank - 2'd1;
         if (enter && nxt == SG)         car_waiting <= 1'b0;
         else if (sensor && cur == MG)   car_waiting <= 1'b1;
      end
   end

`ifdef TLC_WALK_EN
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         walk_pending <= 1'b0;
         walk_light   <= 1'b0;
      end else begin
         walk_light <= (nxt == WALK);
         if (enter && nxt == WALK)        walk_pending <= 1'b0;
         else if (walk_request && cur != WALK) walk_pending <= 1'b1;
      end
   end
`else
   logic unused_walk;
   assign unused_walk  = walk_request;
   assign walk_pending = 1'b0;
   assign walk_light   = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm; expected lights/intervals hand-derived per step.
// Expired is held high for most phases, so each state spans exactly three cycles.
module tb_traffic_light_fsm;

   logic       clk1, rst_n, sensor, walk_request, expired;
   logic       start_timer, walk_light;
   logic [3:0] value;
   logic [1:0] main_light, side_light;
   logic [2:0] state;
   int         vectors, miscompares, cyc;

   traffic_light_fsm dut (
      .clk1(clk1), .rst_n(rst_n), .sensor(sensor), .walk_request(walk_request),
      .expired(expired), .start_timer(start_timer), .value(value),
      .main_light(main_light), .side_light(side_light), .walk_light(walk_light),
      .state(state)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all(input logic [2:0] st, input logic stt, input logic [3:0] val,
                            input logic [1:0] m, input logic [1:0] s, input logic w);
      chk("state", {5'd0, state}, {5'd0, st});
      chk("start_timer", {7'd0, start_timer}, {7'd0, stt});
      chk("value", {4'd0, value}, {4'd0, val});
      chk("main_light", {6'd0, main_light}, {6'd0, m});
      chk("side_light", {6'd0, side_light}, {6'd0, s});
      chk("walk_light", {7'd0, walk_light}, {7'd0, w});
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
      cyc++;
   endtask

   task automatic step(input logic [2:0] st, input logic stt, input logic [3:0] val,
                       input logic [1:0] m, input logic [1:0] s, input logic w);
      tick();
      check_all(st, stt, val, m, s, w);
   endtask

   // Entry cycle plus two blanked cycles; with expired high the next tick leaves the state.
   task automatic enter(input logic [2:0] st, input logic [3:0] val,
                        input logic [1:0] m, input logic [1:0] s, input logic w);
      step(st, 1'b1, val, m, s, w);
      step(st, 1'b0, val, m, s, w);
      step(st, 1'b0, val, m, s, w);
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0;
      rst_n = 1'b0; sensor = 1'b0; walk_request = 1'b0; expired = 1'b0;
      tick(); tick();
      check_all(3'd0, 1'b0, 4'd0, 2'b10, 2'b00, 1'b0);

      // residual expired at release must be ignored by the arm sequence
      expired = 1'b1;
      rst_n   = 1'b1;
      enter(3'd0, 4'd6, 2'b10, 2'b00, 1'b0);
      enter(3'd0, 4'd6, 2'b10, 2'b00, 1'b0);   // re-arm, no car

      // one-cycle sensor blip in MG latches car_waiting; no expired -> hold
      expired = 1'b0; sensor = 1'b1;
      step(3'd0, 1'b0, 4'd6, 2'b10, 2'b00, 1'b0);
      sensor = 1'b0;
      step(3'd0, 1'b0, 4'd6, 2'b10, 2'b00, 1'b0);
      step(3'd0, 1'b0, 4'd6, 2'b10, 2'b00, 1'b0);
      expired = 1'b1;
      enter(3'd1, 4'd2, 2'b01, 2'b00, 1'b0);   // MY
      enter(3'd2, 4'd1, 2'b00, 2'b00, 1'b0);   // AR1
      sensor = 1'b1;
      enter(3'd3, 4'd6, 2'b00, 2'b10, 1'b0);   // SG
      enter(3'd4, 4'd3, 2'b00, 2'b10, 1'b0);   // SGX
      enter(3'd5, 4'd2, 2'b00, 2'b01, 1'b0);   // SY, sensor still high
      sensor = 1'b0;
      enter(3'd6, 4'd1, 2'b00, 2'b00, 1'b0);   // AR2
      enter(3'd0, 4'd6, 2'b10, 2'b00, 1'b0);   // MG
      enter(3'd0, 4'd6, 2'b10, 2'b00, 1'b0);   // re-arm: car_waiting was cleared at SG

      // pedestrian request during MG with a car present
      walk_request = 1'b1; sensor = 1'b1;
      step(3'd1, 1'b1, 4'd2, 2'b01, 2'b00, 1'b0);
      walk_request = 1'b0; sensor = 1'b0;
      step(3'd1, 1'b0, 4'd2, 2'b01, 2'b00, 1'b0);
      step(3'd1, 1'b0, 4'd2, 2'b01, 2'b00, 1'b0);
      enter(3'd2, 4'd1, 2'b00, 2'b00, 1'b0);
`ifdef TLC_WALK_EN
      enter(3'd7, 4'd4, 2'b00, 2'b00, 1'b1);
`endif
      enter(3'd3, 4'd6, 2'b00, 2'b10, 1'b0);
      enter(3'd5, 4'd2, 2'b00, 2'b01, 1'b0);
      enter(3'd6, 4'd1, 2'b00, 2'b00, 1'b0);
      enter(3'd0, 4'd6, 2'b10, 2'b00, 1'b0);

      // drive into SGX, then reset asynchronously mid-interval
      sensor = 1'b1;
      enter(3'd1, 4'd2, 2'b01, 2'b00, 1'b0);
      enter(3'd2, 4'd1, 2'b00, 2'b00, 1'b0);
      enter(3'd3, 4'd6, 2'b00, 2'b10, 1'b0);
      step(3'd4, 1'b1, 4'd3, 2'b00, 2'b10, 1'b0);
      step(3'd4, 1'b0, 4'd3, 2'b00, 2'b10, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_all(3'd0, 1'b0, 4'd0, 2'b10, 2'b00, 1'b0);
      tick();
      check_all(3'd0, 1'b0, 4'd0, 2'b10, 2'b00, 1'b0);
      sensor = 1'b0;
      rst_n  = 1'b1;
      enter(3'd0, 4'd6, 2'b10, 2'b00, 1'b0);
      step(3'd0, 1'b1, 4'd6, 2'b10, 2'b00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
